// File: rtl/count_ctrl_if.sv
// Button inputs and counter-enable outputs of the counter control stage.
// The master side drives the raw buttons; the slave side is the controller.
interface count_ctrl_if;
    logic btn_run_raw;
    logic btn_step_raw;
    logic count_en;
    logic running;

    modport master (
        output btn_run_raw,
        output btn_step_raw,
        input  count_en,
        input  running
    );

    modport slave (
        input  btn_run_raw,
        input  btn_step_raw,
        output count_en,
        output running
    );
endinterface

// File: rtl/count_ctrl.sv
// Run/stop and single-step control for the downstream 4-bit counter:
// button sync + debounce + press detect, then an IDLE/RUN/STEP FSM driving count_en.
module count_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    count_ctrl_if.slave  bus
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PSW = $clog2(PRESCALE);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          press;

    state_e              state_q, state_d;
    logic [PSW-1:0]      presc_q, presc_d;
    logic                count_en_q, count_en_d;
    logic                running_q, running_d;

    logic                run_press;
    logic                step_press;

    // Input synchroniser and debounce
    always_comb begin
        sync1_d = {bus.btn_step_raw, bus.btn_run_raw};
        sync2_d = sync1_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        press    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                // The increment that would reach DEBOUNCE_CYCLES flips the level instead.
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign run_press  = press[BTN_RUN];
    assign step_press = press[BTN_STEP];

    // Control FSM and prescaler
    always_comb begin
        state_d    = state_q;
        presc_d    = '0;
        count_en_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_press) begin
                    state_d = RUN;
                end else if (step_press) begin
                    state_d    = STEP;
                    count_en_d = 1'b1;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_d = IDLE;
                end else if (presc_q == PS_LAST) begin
                    count_en_d = 1'b1;
                end else begin
                    presc_d = presc_q + PSW'(1);
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            count_en_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_en_q <= count_en_d;
            running_q  <= running_d;
        end
    end

    assign bus.count_en = count_en_q;
    assign bus.running  = running_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with DEBOUNCE_CYCLES=3, PRESCALE=4.
// Vector table for press/glitch/hold windows, hand sequences for RUN timing and reset.
module tb_count_ctrl;
    localparam int DEB = 3;
    localparam int PS  = 4;

    typedef struct {
        int run_cyc;
        int step_cyc;
        int win;
        int exp_pulses;
        int exp_run_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic prev_en = 1'b0;
    logic [3:0] ds_cnt = 4'd0;
    logic [3:0] ds_base;
    logic [3:0] ds_delta;
    vec_t vecs [6];

    count_ctrl_if bus ();

    count_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .PRESCALE(PS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, observe 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic s, input logic rn);
        @(negedge clk);
        bus.btn_run_raw  = r;
        bus.btn_step_raw = s;
        reset_n          = rn;
        @(posedge clk);
        #1;
        if (reset_n) begin
            checks++;
            if (bus.count_en && prev_en) begin
                errors++;
                $display("FAIL en_consecutive: count_en high two cycles running at %0t", $time);
            end
            if (bus.count_en) ds_cnt = ds_cnt + 4'd1;
        end
        prev_en = bus.count_en;
    endtask

    initial begin
        int pulses;
        int runc;
        bus.btn_run_raw  = 1'b0;
        bus.btn_step_raw = 1'b0;

        //           run step win pulses running_cycles
        vecs[0] = '{ 2,  0,  20, 0, 0 };   // run glitch rejected
        vecs[1] = '{ 0,  2,  20, 0, 0 };   // step glitch rejected
        vecs[2] = '{ 0,  6,  20, 1, 0 };   // clean step press
        vecs[3] = '{ 0,  50, 70, 1, 0 };   // long hold: one event, release silent
        vecs[4] = '{ 0,  3,  20, 1, 0 };   // shortest accepted press
        vecs[5] = '{ 1,  1,  20, 0, 0 };   // single-cycle blips on both

        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("reset_count_en", bus.count_en, 0);
        chk("reset_running", bus.running, 0);

        ds_base = ds_cnt;
        for (int i = 0; i < 6; i++) begin
            pulses = 0;
            runc   = 0;
            for (int k = 0; k < vecs[i].win; k++) begin
                cyc(k < vecs[i].run_cyc, k < vecs[i].step_cyc, 1'b1);
                pulses += int'(bus.count_en);
                runc   += int'(bus.running);
            end
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            chk($sformatf("vec%0d_running_cycles", i), runc, vecs[i].exp_run_cyc);
        end
        ds_delta = ds_cnt - ds_base;
        chk("step_counter_value", ds_delta, 3);

        // Run press held 6 clocks; step press mid-RUN; stop landing on terminal count.
        for (int k = 0; k < 36; k++) begin
            cyc((k < 6) || (k >= 20 && k < 26), (k >= 9 && k < 15), 1'b1);
            chk($sformatf("run_seq_en_k%0d", k), bus.count_en,
                (k >= 8 && k < 24 && (k % 4) == 0));
            chk($sformatf("run_seq_running_k%0d", k), bus.running, (k >= 4 && k < 24));
        end

        // Coincident presses in IDLE, then asynchronous reset mid-RUN.
        for (int k = 0; k <= 12; k++) begin
            cyc(k < 6, k < 6, 1'b1);
            chk($sformatf("both_seq_en_k%0d", k), bus.count_en, (k >= 8 && (k % 4) == 0));
            chk($sformatf("both_seq_running_k%0d", k), bus.running, (k >= 4));
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_count_en", bus.count_en, 0);
        chk("async_reset_running", bus.running, 0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        pulses = 0;
        runc   = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            pulses += int'(bus.count_en);
            runc   += int'(bus.running);
        end
        chk("post_reset_pulses", pulses, 0);
        chk("post_reset_running_cycles", runc, 0);

        // Run button held through reset release is a fresh press.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk($sformatf("held_reset_en_k%0d", k), bus.count_en, (k == 8));
            chk($sformatf("held_reset_running_k%0d", k), bus.running, (k >= 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
